// File: rtl/finn_rtl_krnl_adder_arbiter.sv
// Packet-level round-robin arbiter sharing one adder datapath between C_NUM_PORTS streams.
// The grant is held until the granted port's tlast beat is accepted; its constant is latched per packet.
module finn_rtl_krnl_adder_arbiter #(
  parameter int C_NUM_PORTS        = 4,
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_ADDER_BIT_WIDTH  = 32,
  parameter int C_TID_WIDTH        = (C_NUM_PORTS > 1) ? $clog2(C_NUM_PORTS) : 1
) (
  input  logic                                        aclk,
  input  logic                                        aresetn,
  input  logic [C_NUM_PORTS-1:0]                      ctrl_port_enable,
  input  logic [C_NUM_PORTS*C_ADDER_BIT_WIDTH-1:0]    ctrl_constant,
  input  logic [C_NUM_PORTS-1:0]                      s_axis_tvalid,
  output logic [C_NUM_PORTS-1:0]                      s_axis_tready,
  input  logic [C_NUM_PORTS*C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_NUM_PORTS*C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [C_NUM_PORTS-1:0]                      s_axis_tlast,
  output logic                                        m_axis_tvalid,
  input  logic                                        m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]               m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0]             m_axis_tkeep,
  output logic                                        m_axis_tlast,
  output logic [C_TID_WIDTH-1:0]                      m_axis_tid,
  output logic [C_ADDER_BIT_WIDTH-1:0]                m_constant,
  output logic                                        busy
);

  localparam int KW = C_AXIS_TDATA_WIDTH / 8;

  typedef enum logic {IDLE, XFER} state_t;

  state_t                 state_q, state_d;
  logic [C_TID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [C_TID_WIDTH-1:0] grant_q, grant_d;
  logic [C_TID_WIDTH-1:0] pick;
  logic                   pick_vld;
  logic                   load_grant;
  logic                   accept;
  logic                   out_ready;
  logic                   sel_valid;
  logic                   sel_last;
  logic [C_NUM_PORTS-1:0] req;

  assign req       = s_axis_tvalid & ctrl_port_enable;
  assign out_ready = ~m_axis_tvalid | m_axis_tready;
  assign sel_valid = s_axis_tvalid[grant_q];
  assign sel_last  = s_axis_tlast[grant_q];
  assign busy      = (state_q == XFER) | m_axis_tvalid;

  // Scan order rr_ptr+1, rr_ptr+2, ... modulo C_NUM_PORTS; the first hit wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int unsigned k = 0; k < C_NUM_PORTS; k++) begin
      for (int unsigned p = 0; p < C_NUM_PORTS; p++) begin
        if (!pick_vld && req[p] &&
            ((32'(rr_ptr_q) + k + 1) % C_NUM_PORTS) == p) begin
          pick     = C_TID_WIDTH'(p);
          pick_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_d       = grant_q;
    s_axis_tready = '0;
    load_grant    = 1'b0;
    accept        = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Waiting for the output register to empty keeps m_constant stable under the last beat.
        if (pick_vld && !m_axis_tvalid) begin
          grant_d    = pick;
          load_grant = 1'b1;
          state_d    = XFER;
        end
      end
      XFER: begin
        s_axis_tready[grant_q] = out_ready;
        if (sel_valid && out_ready) begin
          accept = 1'b1;
          if (sel_last) begin
            rr_ptr_d = grant_q;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= IDLE;
      rr_ptr_q      <= C_TID_WIDTH'(C_NUM_PORTS - 1);
      grant_q       <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tid    <= '0;
      m_constant    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      if (load_grant) begin
        m_constant <= ctrl_constant[pick*C_ADDER_BIT_WIDTH +: C_ADDER_BIT_WIDTH];
      end
      if (accept) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= sel_last;
        m_axis_tid    <= grant_q;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (accept) begin
      m_axis_tdata <= s_axis_tdata[grant_q*C_AXIS_TDATA_WIDTH +: C_AXIS_TDATA_WIDTH];
      m_axis_tkeep <= s_axis_tkeep[grant_q*KW +: KW];
    end
  end

endmodule

// File: tb/tb_finn_rtl_krnl_adder_arbiter.sv
// Bench for finn_rtl_krnl_adder_arbiter: cycle table, hand sequences and randomized
// traffic checked against a packet-level round-robin model.
module tb_finn_rtl_krnl_adder_arbiter;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int KW = DW / 8;
  localparam int CW = 32;
  localparam int TW = 2;

  logic              aclk    = 1'b0;
  logic              aresetn = 1'b1;
  logic [NP-1:0]     ctrl_port_enable = '0;
  logic [NP*CW-1:0]  ctrl_constant    = '0;
  logic [NP-1:0]     s_tvalid = '0;
  logic [NP-1:0]     s_tready;
  logic [NP*DW-1:0]  s_tdata  = '0;
  logic [NP*KW-1:0]  s_tkeep  = '0;
  logic [NP-1:0]     s_tlast  = '0;
  logic              m_tvalid;
  logic              m_tready = 1'b0;
  logic [DW-1:0]     m_tdata;
  logic [KW-1:0]     m_tkeep;
  logic              m_tlast;
  logic [TW-1:0]     m_tid;
  logic [CW-1:0]     m_constant;
  logic              busy;

  finn_rtl_krnl_adder_arbiter #(
    .C_NUM_PORTS       (NP),
    .C_AXIS_TDATA_WIDTH(DW),
    .C_ADDER_BIT_WIDTH (CW),
    .C_TID_WIDTH       (TW)
  ) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .ctrl_port_enable(ctrl_port_enable),
    .ctrl_constant   (ctrl_constant),
    .s_axis_tvalid   (s_tvalid),
    .s_axis_tready   (s_tready),
    .s_axis_tdata    (s_tdata),
    .s_axis_tkeep    (s_tkeep),
    .s_axis_tlast    (s_tlast),
    .m_axis_tvalid   (m_tvalid),
    .m_axis_tready   (m_tready),
    .m_axis_tdata    (m_tdata),
    .m_axis_tkeep    (m_tkeep),
    .m_axis_tlast    (m_tlast),
    .m_axis_tid      (m_tid),
    .m_constant      (m_constant),
    .busy            (busy)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [TW-1:0] tid;
    logic [CW-1:0] cst;
    bit            first;
  } obeat_t;

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          l;
    logic          e_tready;
    logic          e_mvalid;
    logic [DW-1:0] e_mdata;
    logic          e_mlast;
    logic          e_busy;
  } vec_t;

  int unsigned   n_checks = 0;
  int unsigned   n_fail   = 0;
  beat_t         src_q[NP][$];
  obeat_t        exp_q[$];
  int unsigned   obs_tids[$];
  int unsigned   exp_order[$];
  logic [CW-1:0] cst[NP];
  int unsigned   model_ptr = NP - 1;
  vec_t          tbl[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive(input int p, input logic v, input logic [DW-1:0] d, input logic l);
    s_tvalid[p]          = v;
    s_tdata[p*DW +: DW]  = d;
    s_tkeep[p*KW +: KW]  = '1;
    s_tlast[p]           = l;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tvalid"},   m_tvalid,   '0);
    chk({tag, "_tlast"},    m_tlast,    '0);
    chk({tag, "_tid"},      m_tid,      '0);
    chk({tag, "_constant"}, m_constant, '0);
    chk({tag, "_busy"},     busy,       '0);
    chk({tag, "_s_tready"}, s_tready,   '0);
  endtask

  task automatic do_reset(input bit check);
    @(posedge aclk);
    #2;
    aresetn          = 1'b0;
    s_tvalid         = '0;
    s_tlast          = '0;
    ctrl_port_enable = '0;
    m_tready         = 1'b0;
    #1;
    if (check) chk_reset_outputs("reset");
    @(posedge aclk);
    #1;
    aresetn   = 1'b1;
    model_ptr = NP - 1;
    for (int p = 0; p < NP; p++) src_q[p].delete();
    exp_q.delete();
  endtask

  task automatic add_pkt(input int p, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = $urandom;
      b.keep = KW'($urandom);
      b.last = (i == len - 1);
      src_q[p].push_back(b);
    end
  endtask

  // Packet-level reference: every enabled port with pending packets requests whenever the
  // arbiter is free, so the output is whole packets in round-robin order from model_ptr.
  task automatic build_model(input logic [NP-1:0] en);
    int unsigned rd[NP];
    bit          found;
    bit          first;
    int unsigned p;
    beat_t       b;
    obeat_t      o;
    for (int i = 0; i < NP; i++) rd[i] = 0;
    exp_q.delete();
    do begin
      found = 0;
      for (int k = 1; k <= NP; k++) begin
        p = (model_ptr + k) % NP;
        if (!found && en[p] && rd[p] < src_q[p].size()) begin
          found = 1;
          first = 1;
          do begin
            b = src_q[p][rd[p]];
            rd[p]++;
            o.data  = b.data;
            o.keep  = b.keep;
            o.last  = b.last;
            o.tid   = TW'(p);
            o.cst   = cst[p];
            o.first = first;
            first   = 0;
            exp_q.push_back(o);
          end while (!b.last);
          model_ptr = p;
        end
      end
    end while (found);
  endtask

  task automatic run_traffic(input logic [NP-1:0] en, input int tr_pct, input int drop_pct);
    bit     first_b[NP];
    bit     prev_fire;
    int     cyc;
    obeat_t e;
    build_model(en);
    obs_tids.delete();
    ctrl_port_enable = en;
    for (int p = 0; p < NP; p++) begin
      ctrl_constant[p*CW +: CW] = cst[p];
      first_b[p] = 1;
    end
    prev_fire = 0;
    cyc       = 0;
    while (exp_q.size() > 0 && cyc < 4000) begin
      for (int p = 0; p < NP; p++) begin
        if (src_q[p].size() > 0) begin
          s_tvalid[p]         = first_b[p] || ($urandom_range(99) >= drop_pct);
          s_tdata[p*DW +: DW] = src_q[p][0].data;
          s_tkeep[p*KW +: KW] = src_q[p][0].keep;
          s_tlast[p]          = src_q[p][0].last;
        end else begin
          s_tvalid[p] = 1'b0;
        end
      end
      m_tready = ($urandom_range(99) < tr_pct);
      @(negedge aclk);
      chk("tready_disabled_port", s_tready & ~en, '0);
      chk("tready_onehot", ($countones(s_tready) > 1), '0);
      if (m_tvalid) begin
        e = exp_q[0];
        chk("out_tdata",    m_tdata,    e.data);
        chk("out_tkeep",    m_tkeep,    e.keep);
        chk("out_tlast",    m_tlast,    e.last);
        chk("out_tid",      m_tid,      e.tid);
        chk("out_constant", m_constant, e.cst);
        if (e.first) chk("bubble_before_packet", prev_fire, '0);
        if (m_tready) begin
          if (e.first) obs_tids.push_back(int'(m_tid));
          void'(exp_q.pop_front());
        end
      end
      for (int p = 0; p < NP; p++) begin
        if (s_tvalid[p] && s_tready[p] && src_q[p].size() > 0) begin
          first_b[p] = src_q[p][0].last;
          void'(src_q[p].pop_front());
        end
      end
      prev_fire = m_tvalid && m_tready;
      tick();
      cyc++;
    end
    chk("traffic_beats_remaining", exp_q.size(), 0);
    s_tvalid = '0;
    m_tready = 1'b1;
    tick();
    tick();
  endtask

  task automatic chk_order(input string name);
    chk({name, "_count"}, obs_tids.size(), exp_order.size());
    for (int i = 0; i < exp_order.size(); i++) begin
      if (i < obs_tids.size()) chk(name, obs_tids[i], exp_order[i]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    for (int p = 0; p < NP; p++) cst[p] = $urandom;

    // Asynchronous reset between clock edges.
    #12 aresetn = 1'b0;
    #1 chk_reset_outputs("por");
    @(posedge aclk);
    #1 aresetn = 1'b1;

    // Port 0 alone: 3-beat packet, continuous ready.
    tbl[0] = '{1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0};
    tbl[1] = '{1'b1, 32'h11, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b1};
    tbl[2] = '{1'b1, 32'h22, 1'b0, 1'b1, 1'b1, 32'h11, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 32'h33, 1'b1, 1'b1, 1'b1, 32'h22, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 32'h33, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0};
    ctrl_port_enable = 4'b0001;
    m_tready         = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(0, tbl[i].v, tbl[i].d, tbl[i].l);
      @(negedge aclk);
      chk($sformatf("s1_row%0d_s_tready0", i), s_tready[0], tbl[i].e_tready);
      chk($sformatf("s1_row%0d_m_tvalid", i),  m_tvalid,    tbl[i].e_mvalid);
      chk($sformatf("s1_row%0d_busy", i),      busy,        tbl[i].e_busy);
      if (tbl[i].e_mvalid) begin
        chk($sformatf("s1_row%0d_m_tdata", i), m_tdata, tbl[i].e_mdata);
        chk($sformatf("s1_row%0d_m_tlast", i), m_tlast, tbl[i].e_mlast);
        chk($sformatf("s1_row%0d_m_tid", i),   m_tid,   '0);
      end
      tick();
    end

    // Ports 1 and 2, two 2-beat packets each.
    do_reset(1);
    for (int i = 0; i < 2; i++) begin
      add_pkt(1, 2);
      add_pkt(2, 2);
    end
    run_traffic(4'b0110, 100, 0);
    exp_order = '{1, 2, 1, 2};
    chk_order("s2_order");

    // All ports, single-beat packets.
    do_reset(0);
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < NP; p++) add_pkt(p, 1);
    run_traffic(4'b1111, 100, 0);
    exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
    chk_order("s3_order");

    // Port 3: constant changes mid-packet, 4-cycle backpressure.
    do_reset(0);
    ctrl_port_enable       = 4'b1000;
    ctrl_constant[3*CW +: CW] = 32'd5;
    m_tready               = 1'b1;
    drive(3, 1'b1, 32'hA0, 1'b0);
    @(negedge aclk);
    chk("s4_idle_tready", s_tready, '0);
    tick();
    @(negedge aclk);
    chk("s4_grant_tready", s_tready, 4'b1000);
    chk("s4_grant_constant", m_constant, 32'd5);
    chk("s4_grant_tvalid", m_tvalid, '0);
    tick();
    drive(3, 1'b1, 32'hA1, 1'b0);
    ctrl_constant[3*CW +: CW] = 32'd9;
    @(negedge aclk);
    chk("s4_beat0_data", m_tdata, 32'hA0);
    chk("s4_beat0_constant", m_constant, 32'd5);
    tick();
    drive(3, 1'b1, 32'hA2, 1'b0);
    m_tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      chk("s4_hold_tvalid", m_tvalid, 1'b1);
      chk("s4_hold_data", m_tdata, 32'hA1);
      chk("s4_hold_last", m_tlast, 1'b0);
      chk("s4_hold_tid", m_tid, 2'd3);
      chk("s4_hold_constant", m_constant, 32'd5);
      chk("s4_hold_s_tready3", s_tready[3], 1'b0);
      tick();
    end
    m_tready = 1'b1;
    @(negedge aclk);
    chk("s4_release_data", m_tdata, 32'hA1);
    chk("s4_release_tready3", s_tready[3], 1'b1);
    tick();
    drive(3, 1'b1, 32'hA3, 1'b1);
    @(negedge aclk);
    chk("s4_beat2_data", m_tdata, 32'hA2);
    chk("s4_beat2_constant", m_constant, 32'd5);
    tick();
    drive(3, 1'b1, 32'hB0, 1'b1);
    @(negedge aclk);
    chk("s4_last_data", m_tdata, 32'hA3);
    chk("s4_last_tlast", m_tlast, 1'b1);
    chk("s4_last_constant", m_constant, 32'd5);
    chk("s4_last_tready", s_tready, '0);
    tick();
    @(negedge aclk);
    chk("s4_gap_tvalid", m_tvalid, 1'b0);
    chk("s4_gap_tready", s_tready, '0);
    tick();
    @(negedge aclk);
    chk("s4_next_constant", m_constant, 32'd9);
    chk("s4_next_tready", s_tready, 4'b1000);
    tick();
    s_tvalid = '0;
    @(negedge aclk);
    chk("s4_next_data", m_tdata, 32'hB0);
    chk("s4_next_out_constant", m_constant, 32'd9);
    tick();

    // Enable mask 1010 with every port holding packets.
    do_reset(0);
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < NP; p++) add_pkt(p, $urandom_range(1, 3));
    run_traffic(4'b1010, 70, 20);
    exp_order = '{1, 3, 1, 3};
    chk_order("s5_order");

    // Reset mid-packet from port 2 while port 0 requests.
    do_reset(0);
    ctrl_port_enable          = 4'b0101;
    ctrl_constant[0*CW +: CW] = 32'd7;
    ctrl_constant[2*CW +: CW] = 32'd3;
    m_tready                  = 1'b1;
    drive(2, 1'b1, 32'hD0, 1'b0);
    drive(0, 1'b0, 32'h0, 1'b0);
    tick();
    @(negedge aclk);
    chk("s6_grant2_tready", s_tready, 4'b0100);
    tick();
    drive(2, 1'b1, 32'hD1, 1'b0);
    tick();
    drive(2, 1'b1, 32'hD2, 1'b0);
    drive(0, 1'b1, 32'hC0, 1'b1);
    #1;
    chk("s6_pre_tid", m_tid, 2'd2);
    chk("s6_pre_data", m_tdata, 32'hD1);
    aresetn = 1'b0;
    #1 chk_reset_outputs("s6_reset");
    @(posedge aclk);
    #1 aresetn = 1'b1;
    @(negedge aclk);
    chk("s6_idle_tready", s_tready, '0);
    tick();
    @(negedge aclk);
    chk("s6_grant0_tready", s_tready, 4'b0001);
    chk("s6_grant0_constant", m_constant, 32'd7);
    tick();
    drive(0, 1'b0, 32'h0, 1'b0);
    @(negedge aclk);
    chk("s6_out_tvalid", m_tvalid, 1'b1);
    chk("s6_out_tid", m_tid, 2'd0);
    chk("s6_out_data", m_tdata, 32'hC0);
    chk("s6_out_tlast", m_tlast, 1'b1);
    tick();
    s_tvalid = '0;

    // Randomized rounds.
    for (int r = 0; r < 8; r++) begin
      do_reset(0);
      for (int p = 0; p < NP; p++) begin
        cst[p] = $urandom;
        for (int i = 0; i < 3; i++) add_pkt(p, $urandom_range(1, 4));
      end
      run_traffic(NP'($urandom_range(1, 15)), $urandom_range(40, 100), 30);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
